// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  // Clear sequencer states: CLEAR zeroes the array after reset, READY serves issue.
  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Highest-index set bit of a match vector, or -1 when nothing matches.
  // Higher port index means younger instruction, so the last match wins.
  function automatic int port_sel(input logic [31:0] match);
    int sel;
    sel = -1;
    for (int k = 0; k < 32; k++) begin
      if (match[k]) sel = k;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write, reserve and read bundle of the register file.
// Handshake: there is no valid/ready pair. A write or reservation on port k
// is accepted on the rising edge where we[k] / rsv_en[k] is high and busy is
// low. Reads are combinational and always valid while busy is low; while busy
// is high every read returns zero data and a clear pending flag.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 4,
  parameter int NWRITE = 2
) ();

  logic [NWRITE-1:0]        we;
  logic [NWRITE*ADDR_W-1:0] waddr;
  logic [NWRITE*DATA_W-1:0] wdata;
  logic [NWRITE-1:0]        rsv_en;
  logic [NWRITE*ADDR_W-1:0] rsv_addr;
  logic [NREAD*ADDR_W-1:0]  raddr;
  logic [NREAD*DATA_W-1:0]  rdata;
  logic [NREAD-1:0]         rpend;
  logic                     busy;
  rf_state_e                dbg_state;

  modport master (
    output we, waddr, wdata, rsv_en, rsv_addr, raddr,
    input  rdata, rpend, busy, dbg_state
  );

  modport slave (
    input  we, waddr, wdata, rsv_en, rsv_addr, raddr,
    output rdata, rpend, busy, dbg_state
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending bitmap for in-flight destination registers.
module regfile_scoreboard #(
  parameter int DEPTH  = 32,
  parameter int NWRITE = 2,
  parameter int NREAD  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE-1:0]        rsv_en,
  input  logic [NWRITE*ADDR_W-1:0] rsv_addr,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  input  logic [NREAD-1:0]         byp_hit,
  output logic [NREAD-1:0]         rpend
);

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;

  // Next pending map: writebacks clear first, then younger reservations set.
  always_comb begin
    pend_nxt = pend;
    for (int k = 0; k < NWRITE; k++) begin
      if (we[k]) pend_nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    for (int k = 0; k < NWRITE; k++) begin
      if (rsv_en[k]) pend_nxt[rsv_addr[k*ADDR_W +: ADDR_W]] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  // Pending state; frozen while the array is being cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (en) begin
      pend <= pend_nxt;
    end
  end

  // Lookup per read port; a same-cycle bypassed write hides the pending bit.
  always_comb begin
    rpend = '0;
    for (int i = 0; i < NREAD; i++) begin
      rpend[i] = en && pend[raddr[i*ADDR_W +: ADDR_W]] && !byp_hit[i];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with bypass, hardwired r0, pending scoreboard
// and a post-reset clear sequencer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int NREAD      = 4,
  parameter int NWRITE     = 2,
  parameter int BYPASS     = 1,
  parameter int INIT_CLEAR = 1
) (
  input logic        clk,
  input logic        rst,
  regfile_mp_if.slave rf
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_e         state;
  logic [ADDR_W-1:0] ptr;
  logic              ready;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [NREAD-1:0]  byp_hit;

  assign ready        = (state == RF_READY);
  assign rf.busy      = (state == RF_CLEAR);
  assign rf.dbg_state = state;

  // Clear sequencer: walk ptr over every entry once, then hand over to issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (INIT_CLEAR != 0) ? RF_CLEAR : RF_READY;
      ptr   <= '0;
    end else begin
      case (state)
        RF_CLEAR: begin
          if (ptr == ADDR_W'(DEPTH - 1)) state <= RF_READY;
          ptr <= ptr + 1'b1;
        end
        default: state <= RF_READY;
      endcase
    end
  end

  // Array update: clear entry during CLEAR, otherwise writes with the
  // highest port index landing last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[ptr] <= '0;
    end else begin
      for (int k = 0; k < NWRITE; k++) begin
        if (rf.we[k] && (rf.waddr[k*ADDR_W +: ADDR_W] != '0)) begin
          mem[rf.waddr[k*ADDR_W +: ADDR_W]] <= rf.wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [31:0]       match;
    int                sel;
    logic [DATA_W-1:0] val;

    assign ra = rf.raddr[i*ADDR_W +: ADDR_W];

    // Which write ports target this read address in the current cycle.
    always_comb begin
      match = '0;
      for (int k = 0; k < NWRITE; k++) begin
        match[k] = rf.we[k] && (rf.waddr[k*ADDR_W +: ADDR_W] == ra);
      end
    end

    assign sel        = port_sel(match);
    assign byp_hit[i] = (BYPASS != 0) && (sel >= 0);

    // Read mux: zero for r0 or while clearing, youngest bypass, else array.
    always_comb begin
      val = mem[ra];
      if (!ready || (ra == '0)) begin
        val = '0;
      end else if (byp_hit[i]) begin
        val = rf.wdata[sel*DATA_W +: DATA_W];
      end
    end

    assign rf.rdata[i*DATA_W +: DATA_W] = val;
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .NWRITE(NWRITE),
    .NREAD (NREAD)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .en      (ready),
    .we      (rf.we),
    .waddr   (rf.waddr),
    .rsv_en  (rf.rsv_en),
    .rsv_addr(rf.rsv_addr),
    .raddr   (rf.raddr),
    .byp_hit (byp_hit),
    .rpend   (rf.rpend)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: identical stimulus to a bypassing and a non-bypassing
// register file, checked against hand-computed values.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(4), .NWRITE(2)) ifa ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(4), .NWRITE(2)) ifb ();

  regfile_mp #(.BYPASS(1), .INIT_CLEAR(1)) dut_a (.clk(clk), .rst(rst), .rf(ifa));
  regfile_mp #(.BYPASS(0), .INIT_CLEAR(1)) dut_b (.clk(clk), .rst(rst), .rf(ifb));

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks: every stimulus goes to both instances
  task automatic idle();
    ifa.we = '0; ifa.rsv_en = '0;
    ifb.we = '0; ifb.rsv_en = '0;
  endtask

  task automatic set_we(input int k, input logic [4:0] a, input logic [31:0] d);
    ifa.we[k] = 1'b1; ifa.waddr[k*5 +: 5] = a; ifa.wdata[k*32 +: 32] = d;
    ifb.we[k] = 1'b1; ifb.waddr[k*5 +: 5] = a; ifb.wdata[k*32 +: 32] = d;
  endtask

  task automatic set_rsv(input int k, input logic [4:0] a);
    ifa.rsv_en[k] = 1'b1; ifa.rsv_addr[k*5 +: 5] = a;
    ifb.rsv_en[k] = 1'b1; ifb.rsv_addr[k*5 +: 5] = a;
  endtask

  task automatic set_ra(input int i, input logic [4:0] a);
    ifa.raddr[i*5 +: 5] = a;
    ifb.raddr[i*5 +: 5] = a;
  endtask

  // One rising edge, then new inputs go in on the falling edge with writes idle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  // Count busy cycles; optionally inject a write and reservation mid-clear.
  task automatic count_busy(output int cnt, input int pulse_at);
    cnt = 0;
    while (ifa.busy && cnt < 100) begin
      if (cnt == pulse_at) begin
        set_we(0, 5'd5, 32'h5A5A5A5A);
        set_rsv(1, 5'd6);
      end
      step();
      cnt++;
    end
  endtask

  function automatic logic [31:0] rda(input int i);
    return ifa.rdata[i*32 +: 32];
  endfunction

  function automatic logic [31:0] rdb(input int i);
    return ifb.rdata[i*32 +: 32];
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    ifa.waddr = '0; ifa.wdata = '0; ifa.rsv_addr = '0; ifa.raddr = '0;
    ifb.waddr = '0; ifb.wdata = '0; ifb.rsv_addr = '0; ifb.raddr = '0;
    repeat (2) @(negedge clk);

    // Reset state
    #1;
    chk("rst_busy", 32'(ifa.busy), 32'd1);
    chk("rst_state", 32'(ifa.dbg_state), 32'(RF_CLEAR));
    chk("rst_rdata", rda(0), 32'd0);
    chk("rst_rpend", 32'(ifa.rpend), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_busy(n, -1);
    chk("clear_cycles", 32'(n), 32'd32);
    chk("ready_state", 32'(ifa.dbg_state), 32'(RF_READY));

    // Preload every register with all ones
    for (int a = 1; a < 32; a += 2) begin
      set_we(0, 5'(a), 32'hFFFFFFFF);
      if (a + 1 < 32) set_we(1, 5'(a + 1), 32'hFFFFFFFF);
      step();
    end
    set_ra(0, 5'd9);
    #1;
    chk("preload_a_r9", rda(0), 32'hFFFFFFFF);
    chk("preload_b_r9", rdb(0), 32'hFFFFFFFF);

    // Reset again: reads masked during clear, all zero afterwards
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("clear_rd_masked", rda(0), 32'd0);
    rst = 1'b0;
    count_busy(n, -1);
    chk("clear2_cycles", 32'(n), 32'd32);
    for (int base = 0; base < 32; base += 4) begin
      for (int i = 0; i < 4; i++) set_ra(i, 5'(base + i));
      #1;
      for (int i = 0; i < 4; i++) chk($sformatf("zero_r%0d", base + i), rda(i), 32'd0);
      @(negedge clk);
    end
    chk("zero_b_r31", rdb(3), 32'd0);

    // Same-address write collision: port 1 wins
    set_ra(0, 5'd5);
    set_we(0, 5'd5, 32'h11111111);
    set_we(1, 5'd5, 32'h22222222);
    #1;
    chk("coll_byp_a", rda(0), 32'h22222222);
    chk("coll_nobyp_b", rdb(0), 32'd0);
    step();
    #1;
    chk("coll_mem_a", rda(0), 32'h22222222);
    chk("coll_mem_b", rdb(0), 32'h22222222);

    // r0 is hardwired zero
    set_ra(0, 5'd0);
    set_we(0, 5'd0, 32'hDEADBEEF);
    #1;
    chk("r0_same_a", rda(0), 32'd0);
    chk("r0_same_b", rdb(0), 32'd0);
    step();
    #1;
    chk("r0_later_a", rda(0), 32'd0);
    chk("r0_later_b", rdb(0), 32'd0);

    // Scoreboard: reserve, then write+reserve (set wins), then write clears
    set_ra(1, 5'd7);
    set_rsv(0, 5'd7);
    #1;
    chk("rsv_not_yet", 32'(ifa.rpend[1]), 32'd0);
    step();
    #1;
    chk("rsv_set_a", 32'(ifa.rpend[1]), 32'd1);
    chk("rsv_set_b", 32'(ifb.rpend[1]), 32'd1);
    set_we(1, 5'd7, 32'h77777777);
    set_rsv(0, 5'd7);
    #1;
    chk("rsv_byp_forced_a", 32'(ifa.rpend[1]), 32'd0);
    chk("rsv_nobyp_b", 32'(ifb.rpend[1]), 32'd1);
    chk("rsv_byp_data_a", rda(1), 32'h77777777);
    step();
    #1;
    chk("set_wins_a", 32'(ifa.rpend[1]), 32'd1);
    chk("set_wins_b", 32'(ifb.rpend[1]), 32'd1);
    set_we(1, 5'd7, 32'h88888888);
    step();
    #1;
    chk("wr_clears_a", 32'(ifa.rpend[1]), 32'd0);
    chk("wr_clears_b", 32'(ifb.rpend[1]), 32'd0);
    chk("wr_data_a", rda(1), 32'h88888888);

    // No-bypass read of a pending register being written
    set_ra(2, 5'd3);
    set_rsv(0, 5'd3);
    step();
    set_we(0, 5'd3, 32'hA5A5A5A5);
    #1;
    chk("nobyp_old_b", rdb(2), 32'd0);
    chk("nobyp_pend_b", 32'(ifb.rpend[2]), 32'd1);
    chk("byp_new_a", rda(2), 32'hA5A5A5A5);
    chk("byp_pend_a", 32'(ifa.rpend[2]), 32'd0);
    step();
    #1;
    chk("nobyp_next_b", rdb(2), 32'hA5A5A5A5);
    chk("nobyp_clr_b", 32'(ifb.rpend[2]), 32'd0);

    // Reset mid-clear restarts the full sequence; writes during clear drop
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) step();
    #1;
    chk("midclr_busy", 32'(ifa.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rerst_busy", 32'(ifa.busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    count_busy(n, 20);
    chk("restart_cycles", 32'(n), 32'd32);
    set_ra(0, 5'd5);
    set_ra(1, 5'd6);
    set_ra(2, 5'd7);
    #1;
    chk("clr_we_drop_a", rda(0), 32'd0);
    chk("clr_we_drop_b", rdb(0), 32'd0);
    chk("clr_rsv_drop", 32'(ifa.rpend[1]), 32'd0);
    chk("clr_r7_zero", rda(2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
